// File: rtl/fc_mac.sv
// Multiply-accumulate front end of one fully-connected neuron lane: streams N_IN
// activation/weight beats, saturates the dot product to 23 bits and schedules wr_en.
module fc_mac #(
   parameter int N_IN   = 400,
   parameter int W_FRAC = 7,
   parameter int ACC_W  = 32,
   parameter int WR_DLY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] act_in,
   input  logic [7:0]  w_in,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [22:0] d_out,
   output logic        d_valid,
   output logic        wr_en,
   output logic        busy
);

   localparam int CNT_W = $clog2(N_IN);
   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(4194303);
   localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

   typedef enum logic [1:0] {IDLE, ACC, DRAIN, OUT} state_t;

   state_t                    state_reg, state_next;
   logic [CNT_W-1:0]          cnt_reg;
   logic                      drain_reg;
   logic signed [23:0]        prod_full;
   logic signed [23:0]        prod_reg;
   logic                      prod_vld_reg;
   logic signed [ACC_W-1:0]   prod_ext;
   logic signed [ACC_W-1:0]   acc_reg;
   logic [22:0]               sat_val;
   logic [22:0]               d_out_reg;
   logic [WR_DLY-1:0]         dly_reg;
   logic                      beat;
   logic                      last_beat;
   logic                      launch;

   assign beat      = in_valid && (state_reg == ACC);
   assign last_beat = beat && (cnt_reg == CNT_W'(N_IN - 1));
   assign launch    = (state_reg == IDLE) && start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = ACC;
         ACC:     if (last_beat) state_next = DRAIN;
         DRAIN:   if (drain_reg) state_next = OUT;
         OUT:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready = (state_reg == ACC);
      busy     = (state_reg != IDLE);
      d_valid  = (state_reg == OUT);
   end

   // Second DRAIN cycle is the one in which the accumulator holds the final sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg   <= '0;
         drain_reg <= 1'b0;
      end else begin
         drain_reg <= (state_reg == DRAIN) && !drain_reg;
         if (launch)    cnt_reg <= '0;
         else if (beat) cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   assign prod_full = $signed(act_in) * $signed(w_in);
   assign prod_ext  = {{(ACC_W-24){prod_reg[23]}}, prod_reg};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_reg     <= '0;
         prod_vld_reg <= 1'b0;
         acc_reg      <= '0;
      end else begin
         prod_vld_reg <= beat;
         if (beat) prod_reg <= prod_full >>> W_FRAC;
         if (launch)            acc_reg <= '0;
         else if (prod_vld_reg) acc_reg <= acc_reg + prod_ext;
      end
   end

   always_comb begin
      if (acc_reg > SAT_HI)      sat_val = 23'h3FFFFF;
      else if (acc_reg < SAT_LO) sat_val = 23'h400000;
      else                       sat_val = acc_reg[22:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                d_out_reg <= '0;
      else if ((state_reg == DRAIN) && drain_reg) d_out_reg <= sat_val;
   end

   assign d_out = d_out_reg;

   // Free-running delay line so a back-to-back start never disturbs a pending wr_en.
   for (genvar gi = 0; gi < WR_DLY; gi++) begin : g_wr_dly
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)       dly_reg[gi] <= 1'b0;
         else if (gi == 0) dly_reg[gi] <= d_valid;
         else              dly_reg[gi] <= dly_reg[(gi == 0) ? 0 : gi-1];
      end
   end

   assign wr_en = dly_reg[WR_DLY-1];

endmodule

// File: tb/tb_fc_mac.sv
// Directed bench for fc_mac: an N_IN=4 lane for timing/arithmetic cases and an
// N_IN=200 lane for saturation, sharing clock, reset and beat inputs.
module tb_fc_mac;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        go;
   logic        sel;
   logic [15:0] act;
   logic [7:0]  w;
   logic        in_valid;

   logic        ir4, dv4, we4, busy4;
   logic [22:0] dout4;
   logic        ir200, dv200, we200, busy200;
   logic [22:0] dout200;
   logic        start4, start200;

   logic        ir_m, dv_m, we_m, busy_m;
   logic [22:0] dout_m;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign start4   = go & ~sel;
   assign start200 = go & sel;
   assign ir_m     = sel ? ir200   : ir4;
   assign dv_m     = sel ? dv200   : dv4;
   assign we_m     = sel ? we200   : we4;
   assign busy_m   = sel ? busy200 : busy4;
   assign dout_m   = sel ? dout200 : dout4;

   fc_mac #(.N_IN(4), .W_FRAC(7), .ACC_W(32), .WR_DLY(2)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .act_in(act), .w_in(w),
      .in_valid(in_valid), .in_ready(ir4), .d_out(dout4), .d_valid(dv4),
      .wr_en(we4), .busy(busy4)
   );

   fc_mac #(.N_IN(200), .W_FRAC(7), .ACC_W(32), .WR_DLY(2)) dut200 (
      .clk(clk), .rst_n(rst_n), .start(start200), .act_in(act), .w_in(w),
      .in_valid(in_valid), .in_ready(ir200), .d_out(dout200), .d_valid(dv200),
      .wr_en(we200), .busy(busy200)
   );

   typedef struct {
      string       name;
      logic        sel;
      logic [15:0] act;
      logic [7:0]  w;
      logic        stall;
      logic [22:0] exp;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
      end
   endtask

   // Start pulse in IDLE with a junk beat on the bus that must not be taken.
   task automatic do_start();
      go = 1'b1; in_valid = 1'b1; act = 16'h7FFF; w = 8'h7F;
      @(negedge clk);
      go = 1'b0; in_valid = 1'b0;
      chk("start_in_ready", 32'(ir_m), 32'd1);
      chk("start_busy", 32'(busy_m), 32'd1);
   endtask

   task automatic feed(input int n, input logic [15:0] a, input logic [7:0] b,
                       input logic stall, input logic mid_start);
      int acc = 0;
      int cyc = 0;
      logic v;
      while (acc < n && cyc < 1000) begin
         v = !(stall && (cyc % 2 == 1));
         in_valid = v;
         act = v ? a : 16'h7FFF;
         w   = v ? b : 8'h7F;
         go  = mid_start && (acc == 1);
         if (v) chk("beat_in_ready", 32'(ir_m), 32'd1);
         @(negedge clk);
         if (v) acc++;
         cyc++;
      end
      if (acc < n) chk("feed_timeout", 32'(acc), 32'(n));
      in_valid = 1'b0;
      go = 1'b0;
   endtask

   // k counts cycles after the last accepted beat: d_valid at k=3, wr_en at k=5.
   task automatic tail(input logic [22:0] exp, input logic mid_start, input logic b2b);
      for (int k = 1; k <= 7; k++) begin
         chk("tail_d_valid", 32'(dv_m), 32'(k == 3));
         chk("tail_wr_en", 32'(we_m), 32'(k == 5));
         chk("tail_busy", 32'(busy_m), 32'((k <= 3) || (b2b && k >= 5)));
         chk("tail_in_ready", 32'(ir_m), 32'(b2b && k >= 5));
         if (k == 3 || k == 7) chk("tail_d_out", 32'(dout_m), 32'(exp));
         go = (mid_start && k <= 3) || (b2b && k == 4);
         @(negedge clk);
      end
      go = 1'b0;
      $display("result sel=%0d d_out=%h expected=%h", sel, dout_m, exp);
   endtask

   initial begin
      vecs[0] = '{"pos",       1'b0, 16'h0080, 8'h40, 1'b0, 23'h000100};
      vecs[1] = '{"neg_stall", 1'b0, 16'h0080, 8'hC0, 1'b1, 23'h7FFF00};
      vecs[2] = '{"neg_neg",   1'b0, 16'hFF80, 8'h81, 1'b0, 23'h0001FC};
      vecs[3] = '{"floor",     1'b0, 16'h0001, 8'hFF, 1'b1, 23'h7FFFFC};
      vecs[4] = '{"sat_hi",    1'b1, 16'h8000, 8'h80, 1'b0, 23'h3FFFFF};
      vecs[5] = '{"sat_lo",    1'b1, 16'h8000, 8'h7F, 1'b0, 23'h400000};

      rst_n = 1'b0; go = 1'b0; sel = 1'b0; in_valid = 1'b0; act = '0; w = '0;
      repeat (3) @(negedge clk);
      chk("reset_dut4", 32'({ir4, dv4, we4, busy4, dout4}), 32'd0);
      chk("reset_dut200", 32'({ir200, dv200, we200, busy200, dout200}), 32'd0);
      rst_n = 1'b1;
      in_valid = 1'b1; act = 16'h0080; w = 8'h40;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_dut4", 32'({ir4, dv4, we4, busy4, dout4}), 32'd0);
         chk("idle_dut200", 32'({ir200, dv200, we200, busy200, dout200}), 32'd0);
      end
      in_valid = 1'b0;
      $display("idle after reset: checks=%0d errors=%0d", checks, errors);

      for (int i = 0; i < 6; i++) begin
         sel = vecs[i].sel;
         @(negedge clk);
         do_start();
         feed(vecs[i].sel ? 200 : 4, vecs[i].act, vecs[i].w, vecs[i].stall, 1'b0);
         tail(vecs[i].exp, 1'b0, 1'b0);
         $display("vector %s done", vecs[i].name);
      end

      // Reset mid-vector: partial sum discarded, no output pulses, next result clean.
      sel = 1'b0;
      do_start();
      feed(2, 16'h7FFF, 8'h7F, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("abort_d_out", 32'(dout4), 32'd0);
      chk("abort_busy", 32'(busy4), 32'd0);
      chk("abort_in_ready", 32'(ir4), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("abort_quiet", 32'({dv4, we4, busy4}), 32'd0);
      end
      do_start();
      feed(4, 16'h0100, 8'h40, 1'b0, 1'b0);
      tail(23'h000200, 1'b0, 1'b0);
      $display("abort sequence done");

      // start during ACC/DRAIN/OUT is ignored; start right after OUT runs back-to-back.
      do_start();
      feed(4, 16'h0080, 8'h40, 1'b0, 1'b1);
      tail(23'h000100, 1'b1, 1'b1);
      feed(4, 16'h0080, 8'hC0, 1'b0, 1'b0);
      tail(23'h7FFF00, 1'b0, 1'b0);
      $display("back-to-back sequence done");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fc_mac.md
Name: fc_mac

Overview:
- Upstream multiply-accumulate stage of one fully-connected neuron lane.
- Streams N_IN activation/weight pairs, each pair multiplied and rescaled to the activation Q-format, and accumulates a signed dot product.
- Saturates the result to 23 bits and presents it on d_out to the downstream bias-add/ReLU/write unit (23-bit data input, 16-bit bias, internal 2-register pipeline before its write-enabled output register).
- Generates that unit's wr_en pulse aligned to its pipeline.

Parameters:
- N_IN, 400, number of input beats per dot product (>=2).
- W_FRAC, 7, fractional bits of weight; product arithmetic-shifted right by W_FRAC.
- ACC_W, 32, internal signed accumulator width.
- WR_DLY, 2, cycles from d_valid to wr_en (downstream register depth).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin new dot product; accepted only in IDLE.
- act_in  input  16  signed activation, Q8.7.
- w_in  input  8  signed weight, Q0.7.
- in_valid  input  1  act_in/w_in valid.
- in_ready  output  1  beat accepted when in_valid && in_ready.
- d_out  output  23  signed saturated dot product, Q15.7; held until next result.
- d_valid  output  1  one-cycle pulse, d_out updated this cycle.
- wr_en  output  1  one-cycle pulse WR_DLY cycles after d_valid.
- busy  output  1  high in any state except IDLE.

Behaviour:
- Reset (async, rst_n low): state IDLE, in_ready=0, d_out=0, d_valid=0, wr_en=0, busy=0, beat counter=0, accumulator=0, product valid=0, wr_en delay line cleared. Reset mid-vector discards partial sum; no d_valid/wr_en is produced for it.
- States:
  - IDLE: in_ready=0. start=1 -> ACC; accumulator and counter cleared.
  - ACC: in_ready=1. Each accepted beat increments the counter. The beat accepted with counter==N_IN-1 -> DRAIN, with in_ready dropping the next cycle. Cycles with in_valid=0 do not count (stalls allowed, unbounded).
  - DRAIN: in_ready=0. Stays 2 cycles (product stage, accumulate stage), then -> OUT.
  - OUT: registers the saturated accumulator into d_out, asserts d_valid for 1 cycle, then -> IDLE.
  - start outside IDLE is ignored.
  - start in the same cycle as in_valid in IDLE: no beat is taken.
- Pipeline: accepted beat at cycle t -> product register at t+1 -> accumulator at t+2. Last beat accepted at cycle L -> d_valid/d_out at L+3 -> wr_en at L+3+WR_DLY (L+5 default).
- Arithmetic:
  - Product = signed act_in x signed w_in (24 bits), arithmetic shift right W_FRAC (floor), sign-extended to ACC_W, added to the accumulator.
  - No accumulator overflow is possible for N_IN <= 2^(ACC_W-17).
- Output saturation:
  - acc > 2^22-1 -> 23'h3FFFFF.
  - acc < -2^22 -> 23'h400000.
  - else acc[22:0].
- wr_en delay line runs independently of the FSM. A new start in the cycle after OUT is legal and does not disturb a pending wr_en.
- Minimum spacing between results: N_IN+4 cycles with no stalls.

Test Plan:
- Reset then idle, no start -> in_ready=0, d_out=0, d_valid=0, wr_en=0, busy=0 indefinitely.
- N_IN=4, start, 4 beats act=16'h0080, w=8'h40, no stalls -> d_out=23'h000100 with d_valid 3 cycles after last beat, wr_en 2 cycles later, each 1 cycle wide.
- N_IN=4, weights 8'hC0, act 16'h0080, in_valid toggled every other cycle -> only accepted beats counted; d_out=23'h7FFF00 (-256); in_ready low from cycle after 4th beat until IDLE.
- N_IN=200, all beats act=16'h8000, w=8'h80 (+32768 each) -> d_out=23'h3FFFFF; negated weights 8'h7F with act 16'h8000 -> d_out=23'h400000.
- rst_n pulsed low after 2 of 4 beats, then full new vector of act=16'h0100, w=8'h40 -> no output for aborted vector; next result 23'h000200, wr_en still 2 cycles after d_valid.
- start asserted during ACC/DRAIN and again the cycle after OUT -> mid-vector start ignored; back-to-back vector accepted and first result's wr_en still fires on schedule.
